// File: rtl/oled_pkg.sv
// Shared definitions for the SSD1331 SPI arbiter slice.
//   arb_state_t        : arbiter FSM states (fixed 2-bit encoding)
//   NUM_REQ_DEF        : default requester count
//   WIDTH_DEF          : default byte width
//   DC_CMD / DC_DATA   : D/C line encoding toward the SSD1331
package oled_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        GRANT     = 2'd1,
        WAIT_LOW  = 2'd2,
        WAIT_HIGH = 2'd3
    } arb_state_t;

    localparam int unsigned NUM_REQ_DEF = 3;
    localparam int unsigned WIDTH_DEF   = 8;

    localparam logic DC_CMD  = 1'b0;
    localparam logic DC_DATA = 1'b1;

endpackage

// File: rtl/oled_spi_arbiter_if.sv
// Bundle between the requester blocks / SPI byte transmitter and the arbiter.
//   i_REQ/i_DATA/i_DC/i_LAST : per-requester byte offer (flattened, requester k
//                              owns i_DATA[k*WIDTH +: WIDTH])
//   o_GNT/o_ACK              : one-hot grant and per-byte take pulse
//   o_START/o_DATA/o_DC      : transmitter start pulse and held byte/D-C
//   i_READY                  : transmitter idle handshake
//   o_BUSY/o_ERR             : arbiter activity and sticky timeout flag
// Modport slave is the arbiter side; master is the environment side.
interface oled_spi_arbiter_if
    import oled_pkg::*;
#(
    parameter int unsigned NUM_REQ = NUM_REQ_DEF,
    parameter int unsigned WIDTH   = WIDTH_DEF
);
    logic [NUM_REQ-1:0]       i_REQ;
    logic [NUM_REQ*WIDTH-1:0] i_DATA;
    logic [NUM_REQ-1:0]       i_DC;
    logic [NUM_REQ-1:0]       i_LAST;
    logic [NUM_REQ-1:0]       o_GNT;
    logic [NUM_REQ-1:0]       o_ACK;
    logic                     o_START;
    logic [WIDTH-1:0]         o_DATA;
    logic                     o_DC;
    logic                     i_READY;
    logic                     o_BUSY;
    logic                     o_ERR;

    modport slave (
        input  i_REQ, i_DATA, i_DC, i_LAST, i_READY,
        output o_GNT, o_ACK, o_START, o_DATA, o_DC, o_BUSY, o_ERR
    );

    modport master (
        output i_REQ, i_DATA, i_DC, i_LAST, i_READY,
        input  o_GNT, o_ACK, o_START, o_DATA, o_DC, o_BUSY, o_ERR
    );
endinterface

// File: rtl/oled_rr_picker.sv
// Combinational round-robin picker: first set bit of req at or above ptr,
// wrapping from NUM_REQ-1 back to 0.
//   req : request vector
//   ptr : search start index
//   gnt : one-hot winner (all zero when nothing requested)
//   idx : binary index of the winner
//   any : at least one request present
module oled_rr_picker
    import oled_pkg::*;
#(
    parameter int unsigned NUM_REQ = NUM_REQ_DEF,
    localparam int unsigned IDX_W  = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   idx,
    output logic               any
);
    always_comb begin
        logic [IDX_W-1:0] k;
        gnt = '0;
        idx = '0;
        any = 1'b0;
        k   = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            k = IDX_W'((32'(ptr) + i) % NUM_REQ);
            if (!any && req[k]) begin
                any    = 1'b1;
                idx    = k;
                gnt[k] = 1'b1;
            end
        end
    end
endmodule

// File: rtl/oled_spi_arbiter.sv
// Round-robin arbiter/sequencer sharing one SSD1331 SPI byte transmitter
// between several requesters, with burst lock on i_LAST.
//   i_CLK : system clock
//   i_RST : synchronous active-high reset
//   bus   : oled_spi_arbiter_if.slave (requester offers, grant/ack,
//           transmitter start/byte/ready, busy/error status)
// Optional: define OLED_ARB_TIMEOUT_EN to enable the WAIT_LOW/WAIT_HIGH
// watchdog (TIMEOUT_CYCLES) and the sticky o_ERR flag; otherwise o_ERR is 0.
module oled_spi_arbiter
    import oled_pkg::*;
#(
    parameter int unsigned NUM_REQ        = NUM_REQ_DEF,
    parameter int unsigned WIDTH          = WIDTH_DEF,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic               i_CLK,
    input  logic               i_RST,
    oled_spi_arbiter_if.slave  bus
);
    localparam int unsigned IDX_W = $clog2(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
        $error("oled_spi_arbiter: NUM_REQ must be 2..8");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("oled_spi_arbiter: TIMEOUT_CYCLES must be at least 1");
    end

    arb_state_t           state_q, state_d;
    logic [IDX_W-1:0]     ptr_q, ptr_d;
    logic [IDX_W-1:0]     gidx_q, gidx_d;
    logic [NUM_REQ-1:0]   gnt_q, gnt_d;
    logic [NUM_REQ-1:0]   ack_q, ack_d;
    logic                 start_q, start_d;
    logic [WIDTH-1:0]     data_q, data_d;
    logic                 dc_q, dc_d;
    logic                 last_q, last_d;
    logic                 busy_q;
    logic                 timeout;

    logic [NUM_REQ-1:0]   pick_gnt;
    logic [IDX_W-1:0]     pick_idx;
    logic                 pick_any;
    logic [WIDTH-1:0]     data_arr [NUM_REQ];

    for (genvar k = 0; k < NUM_REQ; k++) begin : g_unpack
        assign data_arr[k] = bus.i_DATA[k*WIDTH +: WIDTH];
    end

    function automatic logic [IDX_W-1:0] next_ptr(input logic [IDX_W-1:0] g);
        return (g == IDX_W'(NUM_REQ - 1)) ? '0 : g + 1'b1;
    endfunction

    oled_rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
        .req (bus.i_REQ),
        .ptr (ptr_q),
        .gnt (pick_gnt),
        .idx (pick_idx),
        .any (pick_any)
    );

`ifdef OLED_ARB_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] tmo_q;
    logic             err_q;

    // tmo_q counts cycles spent in the current state and saturates one below
    // the limit, so the watchdog fires on the TIMEOUT_CYCLES-th waiting cycle.
    assign timeout = (state_q == WAIT_LOW || state_q == WAIT_HIGH) &&
                     (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            tmo_q <= '0;
            err_q <= 1'b0;
        end else begin
            if (state_d != state_q)
                tmo_q <= '0;
            else if (tmo_q != TMO_W'(TIMEOUT_CYCLES - 1))
                tmo_q <= tmo_q + 1'b1;
            if (timeout)
                err_q <= 1'b1;
        end
    end

    assign bus.o_ERR = err_q;
`else
    assign timeout   = 1'b0;
    assign bus.o_ERR = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gidx_d  = gidx_q;
        gnt_d   = gnt_q;
        ack_d   = '0;
        start_d = 1'b0;
        data_d  = data_q;
        dc_d    = dc_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    gnt_d   = pick_gnt;
                    gidx_d  = pick_idx;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (!bus.i_REQ[gidx_q]) begin
                    gnt_d   = '0;
                    state_d = IDLE;
                end else if (bus.i_READY) begin
                    start_d        = 1'b1;
                    ack_d[gidx_q]  = 1'b1;
                    data_d         = data_arr[gidx_q];
                    dc_d           = bus.i_DC[gidx_q];
                    last_d         = bus.i_LAST[gidx_q];
                    state_d        = WAIT_LOW;
                end
            end
            WAIT_LOW: begin
                if (!bus.i_READY)
                    state_d = WAIT_HIGH;
            end
            WAIT_HIGH: begin
                if (bus.i_READY) begin
                    if (last_q || !bus.i_REQ[gidx_q]) begin
                        gnt_d   = '0;
                        ptr_d   = next_ptr(gidx_q);
                        state_d = IDLE;
                    end else begin
                        state_d = GRANT;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        // Watchdog abort overrides whatever the wait states decided.
        if (timeout) begin
            gnt_d   = '0;
            ptr_d   = next_ptr(gidx_q);
            state_d = IDLE;
        end
    end

    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            gidx_q  <= '0;
            gnt_q   <= '0;
            ack_q   <= '0;
            start_q <= 1'b0;
            data_q  <= '0;
            dc_q    <= DC_CMD;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gidx_q  <= gidx_d;
            gnt_q   <= gnt_d;
            ack_q   <= ack_d;
            start_q <= start_d;
            data_q  <= data_d;
            dc_q    <= dc_d;
            last_q  <= last_d;
            // Registered from the next state so o_BUSY lines up with state_q.
            busy_q  <= (state_d != IDLE);
        end
    end

    assign bus.o_GNT   = gnt_q;
    assign bus.o_ACK   = ack_q;
    assign bus.o_START = start_q;
    assign bus.o_DATA  = data_q;
    assign bus.o_DC    = dc_q;
    assign bus.o_BUSY  = busy_q;
endmodule

// File: tb/tb_oled_spi_arbiter.sv
// Directed self-checking bench for oled_spi_arbiter (NUM_REQ=3, WIDTH=8,
// TIMEOUT_CYCLES=16). Inputs change and outputs are sampled 1 time unit
// after each rising edge.
module tb_oled_spi_arbiter;
    import oled_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    oled_spi_arbiter_if #(.NUM_REQ(3), .WIDTH(8)) bus ();

    oled_spi_arbiter #(
        .NUM_REQ        (3),
        .WIDTH          (8),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .i_CLK (clk),
        .i_RST (rst),
        .bus   (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_byte(input int k, input logic [7:0] d, input logic dc, input logic last);
        bus.i_DATA[k*8 +: 8] = d;
        bus.i_DC[k]          = dc;
        bus.i_LAST[k]        = last;
    endtask

    // Transmitter behaviour: called on the cycle o_START is visible. READY
    // falls one cycle later, stays low low_cycles cycles, then returns.
    task automatic tx_serve(input int low_cycles);
        tick();
        bus.i_READY = 1'b0;
        repeat (low_cycles) tick();
        bus.i_READY = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.i_REQ = 3'b111;
        bus.i_READY = 1'b1;
        tick();
        tick();
        vectors++; if (bus.o_GNT !== 3'b000) begin miscompares++; $display("FAIL reset_gnt got=%b exp=%b", bus.o_GNT, 3'b000); end
        vectors++; if (bus.o_ACK !== 3'b000) begin miscompares++; $display("FAIL reset_ack got=%b exp=%b", bus.o_ACK, 3'b000); end
        vectors++; if (bus.o_START !== 1'b0) begin miscompares++; $display("FAIL reset_start got=%b exp=0", bus.o_START); end
        vectors++; if (bus.o_DATA !== 8'h00) begin miscompares++; $display("FAIL reset_data got=%h exp=00", bus.o_DATA); end
        vectors++; if (bus.o_DC !== 1'b0) begin miscompares++; $display("FAIL reset_dc got=%b exp=0", bus.o_DC); end
        vectors++; if (bus.o_BUSY !== 1'b0) begin miscompares++; $display("FAIL reset_busy got=%b exp=0", bus.o_BUSY); end
        vectors++; if (bus.o_ERR !== 1'b0) begin miscompares++; $display("FAIL reset_err got=%b exp=0", bus.o_ERR); end
        rst = 1'b0;
        bus.i_REQ = 3'b000;
    endtask

    task automatic test_single_byte();
        set_byte(0, 8'hAE, DC_CMD, 1'b1);
        bus.i_REQ = 3'b001;
        bus.i_READY = 1'b1;
        tick();
        vectors++; if (bus.o_GNT !== 3'b001) begin miscompares++; $display("FAIL single_gnt got=%b exp=%b", bus.o_GNT, 3'b001); end
        vectors++; if (bus.o_START !== 1'b0) begin miscompares++; $display("FAIL single_start_early got=%b exp=0", bus.o_START); end
        vectors++; if (bus.o_BUSY !== 1'b1) begin miscompares++; $display("FAIL single_busy got=%b exp=1", bus.o_BUSY); end
        tick();
        vectors++; if (bus.o_START !== 1'b1) begin miscompares++; $display("FAIL single_start got=%b exp=1", bus.o_START); end
        vectors++; if (bus.o_ACK !== 3'b001) begin miscompares++; $display("FAIL single_ack got=%b exp=%b", bus.o_ACK, 3'b001); end
        vectors++; if (bus.o_DATA !== 8'hAE) begin miscompares++; $display("FAIL single_data got=%h exp=AE", bus.o_DATA); end
        vectors++; if (bus.o_DC !== 1'b0) begin miscompares++; $display("FAIL single_dc got=%b exp=0", bus.o_DC); end
        bus.i_REQ = 3'b000;
        tx_serve(40);
        vectors++; if (bus.o_GNT !== 3'b000) begin miscompares++; $display("FAIL single_gnt_release got=%b exp=%b", bus.o_GNT, 3'b000); end
        vectors++; if (bus.o_BUSY !== 1'b0) begin miscompares++; $display("FAIL single_idle got=%b exp=0", bus.o_BUSY); end
        vectors++; if (bus.o_START !== 1'b0) begin miscompares++; $display("FAIL single_one_start got=%b exp=0", bus.o_START); end
        vectors++; if (bus.o_DATA !== 8'hAE) begin miscompares++; $display("FAIL single_data_hold got=%h exp=AE", bus.o_DATA); end
    endtask

    // Pointer is 1 after the single-byte test, so {0,2} requesting picks 2.
    task automatic test_withdraw();
        set_byte(2, 8'h5C, DC_DATA, 1'b1);
        bus.i_READY = 1'b0;
        bus.i_REQ = 3'b101;
        tick();
        vectors++; if (bus.o_GNT !== 3'b100) begin miscompares++; $display("FAIL wd_ptr_after_single got=%b exp=%b", bus.o_GNT, 3'b100); end
        tick();
        vectors++; if (bus.o_START !== 1'b0) begin miscompares++; $display("FAIL wd_wait_ready got=%b exp=0", bus.o_START); end
        bus.i_REQ = 3'b000;
        tick();
        vectors++; if (bus.o_GNT !== 3'b000) begin miscompares++; $display("FAIL wd_gnt_clear got=%b exp=%b", bus.o_GNT, 3'b000); end
        vectors++; if (bus.o_START !== 1'b0) begin miscompares++; $display("FAIL wd_no_start got=%b exp=0", bus.o_START); end
        vectors++; if (bus.o_ACK !== 3'b000) begin miscompares++; $display("FAIL wd_no_ack got=%b exp=%b", bus.o_ACK, 3'b000); end
        vectors++; if (bus.o_BUSY !== 1'b0) begin miscompares++; $display("FAIL wd_idle got=%b exp=0", bus.o_BUSY); end
        bus.i_REQ = 3'b101;
        bus.i_READY = 1'b1;
        tick();
        vectors++; if (bus.o_GNT !== 3'b100) begin miscompares++; $display("FAIL wd_ptr_unchanged got=%b exp=%b", bus.o_GNT, 3'b100); end
        tick();
        vectors++; if (bus.o_ACK !== 3'b100) begin miscompares++; $display("FAIL wd_ack2 got=%b exp=%b", bus.o_ACK, 3'b100); end
        vectors++; if (bus.o_DATA !== 8'h5C) begin miscompares++; $display("FAIL wd_data2 got=%h exp=5C", bus.o_DATA); end
        vectors++; if (bus.o_DC !== 1'b1) begin miscompares++; $display("FAIL wd_dc2 got=%b exp=1", bus.o_DC); end
        bus.i_REQ = 3'b000;
        tx_serve(2);
    endtask

    task automatic test_burst();
        set_byte(0, 8'hA0, DC_DATA, 1'b0);
        bus.i_REQ = 3'b001;
        tick();
        vectors++; if (bus.o_GNT !== 3'b001) begin miscompares++; $display("FAIL burst_gnt got=%b exp=%b", bus.o_GNT, 3'b001); end
        set_byte(1, 8'hB5, DC_CMD, 1'b1);
        bus.i_REQ = 3'b011;
        tick();
        vectors++; if (bus.o_DATA !== 8'hA0 || bus.o_ACK !== 3'b001) begin miscompares++; $display("FAIL burst_a0 got=%h/%b exp=A0/001", bus.o_DATA, bus.o_ACK); end
        set_byte(0, 8'hA1, DC_DATA, 1'b0);
        tx_serve(3);
        vectors++; if (bus.o_GNT !== 3'b001) begin miscompares++; $display("FAIL burst_lock1 got=%b exp=%b", bus.o_GNT, 3'b001); end
        tick();
        vectors++; if (bus.o_START !== 1'b1 || bus.o_DATA !== 8'hA1) begin miscompares++; $display("FAIL burst_a1 got=%b/%h exp=1/A1", bus.o_START, bus.o_DATA); end
        set_byte(0, 8'hA2, DC_DATA, 1'b1);
        tx_serve(3);
        vectors++; if (bus.o_GNT !== 3'b001) begin miscompares++; $display("FAIL burst_lock2 got=%b exp=%b", bus.o_GNT, 3'b001); end
        tick();
        vectors++; if (bus.o_START !== 1'b1 || bus.o_DATA !== 8'hA2) begin miscompares++; $display("FAIL burst_a2 got=%b/%h exp=1/A2", bus.o_START, bus.o_DATA); end
        bus.i_REQ = 3'b010;
        tx_serve(3);
        vectors++; if (bus.o_GNT !== 3'b000) begin miscompares++; $display("FAIL burst_end got=%b exp=%b", bus.o_GNT, 3'b000); end
        tick();
        vectors++; if (bus.o_GNT !== 3'b010) begin miscompares++; $display("FAIL burst_next_gnt got=%b exp=%b", bus.o_GNT, 3'b010); end
        tick();
        vectors++; if (bus.o_ACK !== 3'b010 || bus.o_DATA !== 8'hB5 || bus.o_DC !== 1'b0) begin miscompares++; $display("FAIL burst_b5 got=%b/%h/%b exp=010/B5/0", bus.o_ACK, bus.o_DATA, bus.o_DC); end
        bus.i_REQ = 3'b000;
        tx_serve(3);
    endtask

    task automatic test_reset_mid();
        set_byte(1, 8'h77, DC_DATA, 1'b1);
        bus.i_REQ = 3'b010;
        tick();
        tick();
        vectors++; if (bus.o_START !== 1'b1 || bus.o_DATA !== 8'h77) begin miscompares++; $display("FAIL rmid_start got=%b/%h exp=1/77", bus.o_START, bus.o_DATA); end
        tick();
        bus.i_READY = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        vectors++; if (bus.o_GNT !== 3'b000) begin miscompares++; $display("FAIL rmid_gnt got=%b exp=%b", bus.o_GNT, 3'b000); end
        vectors++; if (bus.o_DATA !== 8'h00 || bus.o_DC !== 1'b0) begin miscompares++; $display("FAIL rmid_data got=%h/%b exp=00/0", bus.o_DATA, bus.o_DC); end
        vectors++; if (bus.o_BUSY !== 1'b0 || bus.o_START !== 1'b0) begin miscompares++; $display("FAIL rmid_busy got=%b/%b exp=0/0", bus.o_BUSY, bus.o_START); end
        rst = 1'b0;
        bus.i_REQ = 3'b000;
        bus.i_READY = 1'b1;
        tick();
        tick();
        vectors++; if (bus.o_ACK !== 3'b000 || bus.o_START !== 1'b0) begin miscompares++; $display("FAIL rmid_no_ack got=%b/%b exp=000/0", bus.o_ACK, bus.o_START); end
        set_byte(0, 8'h3C, DC_CMD, 1'b1);
        set_byte(2, 8'h4D, DC_CMD, 1'b1);
        bus.i_REQ = 3'b111;
        tick();
        vectors++; if (bus.o_GNT !== 3'b001) begin miscompares++; $display("FAIL rmid_ptr0 got=%b exp=%b", bus.o_GNT, 3'b001); end
        tick();
        vectors++; if (bus.o_ACK !== 3'b001 || bus.o_DATA !== 8'h3C) begin miscompares++; $display("FAIL rmid_clean got=%b/%h exp=001/3C", bus.o_ACK, bus.o_DATA); end
        bus.i_REQ = 3'b000;
        tx_serve(2);
    endtask

    task automatic test_round_robin();
        logic [7:0] rr_data [3];
        logic [2:0] rr_dc;
        logic [2:0] exp_gnt;
        int         e;
        rr_data = '{8'h10, 8'h21, 8'h32};
        rr_dc   = 3'b010;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int k = 0; k < 3; k++) set_byte(k, rr_data[k], rr_dc[k], 1'b1);
        bus.i_REQ = 3'b111;
        bus.i_READY = 1'b1;
        for (int n = 0; n < 4; n++) begin
            e = n % 3;
            exp_gnt = 3'b001 << e;
            tick();
            vectors++; if (bus.o_GNT !== exp_gnt) begin miscompares++; $display("FAIL rr_gnt[%0d] got=%b exp=%b", n, bus.o_GNT, exp_gnt); end
            tick();
            vectors++; if (bus.o_ACK !== exp_gnt || bus.o_START !== 1'b1) begin miscompares++; $display("FAIL rr_ack[%0d] got=%b/%b exp=%b/1", n, bus.o_ACK, bus.o_START, exp_gnt); end
            vectors++; if (bus.o_DATA !== rr_data[e] || bus.o_DC !== rr_dc[e]) begin miscompares++; $display("FAIL rr_data[%0d] got=%h/%b exp=%h/%b", n, bus.o_DATA, bus.o_DC, rr_data[e], rr_dc[e]); end
            tx_serve(3);
            vectors++; if (bus.o_GNT !== 3'b000 || bus.o_BUSY !== 1'b0) begin miscompares++; $display("FAIL rr_release[%0d] got=%b/%b exp=000/0", n, bus.o_GNT, bus.o_BUSY); end
        end
        bus.i_REQ = 3'b000;
    endtask

    // Pointer is 1 here; the stalled transfer is from requester 1, so after
    // release the pointer must be 2 and {0,1} requesting picks 0.
    task automatic test_stall();
        set_byte(1, 8'h99, DC_DATA, 1'b1);
        bus.i_REQ = 3'b010;
        tick();
        tick();
        vectors++; if (bus.o_ACK !== 3'b010) begin miscompares++; $display("FAIL stall_ack got=%b exp=%b", bus.o_ACK, 3'b010); end
        bus.i_READY = 1'b0;
`ifdef OLED_ARB_TIMEOUT_EN
        repeat (16) tick();
        vectors++; if (bus.o_ERR !== 1'b0 || bus.o_GNT !== 3'b010) begin miscompares++; $display("FAIL tmo_early got=%b/%b exp=0/010", bus.o_ERR, bus.o_GNT); end
        tick();
        vectors++; if (bus.o_ERR !== 1'b1) begin miscompares++; $display("FAIL tmo_err got=%b exp=1", bus.o_ERR); end
        vectors++; if (bus.o_GNT !== 3'b000 || bus.o_BUSY !== 1'b0) begin miscompares++; $display("FAIL tmo_release got=%b/%b exp=000/0", bus.o_GNT, bus.o_BUSY); end
        bus.i_REQ = 3'b000;
        bus.i_READY = 1'b1;
        repeat (4) tick();
        vectors++; if (bus.o_ERR !== 1'b1) begin miscompares++; $display("FAIL tmo_sticky got=%b exp=1", bus.o_ERR); end
`else
        repeat (40) tick();
        vectors++; if (bus.o_ERR !== 1'b0 || bus.o_GNT !== 3'b010 || bus.o_BUSY !== 1'b1) begin miscompares++; $display("FAIL stall_wait got=%b/%b/%b exp=0/010/1", bus.o_ERR, bus.o_GNT, bus.o_BUSY); end
        bus.i_READY = 1'b1;
        tick();
        vectors++; if (bus.o_GNT !== 3'b000 || bus.o_BUSY !== 1'b0) begin miscompares++; $display("FAIL stall_release got=%b/%b exp=000/0", bus.o_GNT, bus.o_BUSY); end
`endif
        bus.i_REQ = 3'b011;
        tick();
        vectors++; if (bus.o_GNT !== 3'b001) begin miscompares++; $display("FAIL stall_ptr_adv got=%b exp=%b", bus.o_GNT, 3'b001); end
        bus.i_REQ = 3'b000;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        vectors++; if (bus.o_ERR !== 1'b0 || bus.o_GNT !== 3'b000) begin miscompares++; $display("FAIL stall_rst got=%b/%b exp=0/000", bus.o_ERR, bus.o_GNT); end
    endtask

    initial begin
        bus.i_REQ   = '0;
        bus.i_DATA  = '0;
        bus.i_DC    = '0;
        bus.i_LAST  = '0;
        bus.i_READY = 1'b1;
        tick();
        test_reset();
        test_single_byte();
        test_withdraw();
        test_burst();
        test_reset_mid();
        test_round_robin();
        test_stall();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/oled_spi_arbiter.md
Name: oled_spi_arbiter

Overview:
- Round-robin arbiter and sequencer that shares the single SSD1331 SPI byte transmitter between several requesters: init sequencer, text renderer and pixel/fill engine.
- Each requester presents one byte plus its D/C flag. The block grants one requester at a time, issues a start pulse to the transmitter and waits for the transmitter's READY handshake to complete.
- An optional burst lock keeps the grant until the requester marks its last byte, so command sequences are never interleaved.
- Sits between the requester blocks and the SPI transmitter inside the OLED interface.

Parameters:
- NUM_REQ, 3, number of requesters (2..8).
- WIDTH, 8, bits per transferred byte.
- TIMEOUT_CYCLES, 1000000, watchdog limit in i_CLK cycles. Used only with OLED_ARB_TIMEOUT_EN.

Ports:
- i_CLK  in  1  system clock (100 MHz).
- i_RST  in  1  synchronous active-high reset.
- i_REQ  in  NUM_REQ  per-requester request. Held high until acked.
- i_DATA  in  NUM_REQ*WIDTH  flattened bytes; requester k uses bits [k*WIDTH +: WIDTH].
- i_DC  in  NUM_REQ  per-requester D/C value (0 = command, 1 = data).
- i_LAST  in  NUM_REQ  marks the byte as the last of a burst.
- o_GNT  out  NUM_REQ  one-hot current grant.
- o_ACK  out  NUM_REQ  one-cycle pulse: byte k taken by the transmitter.
- o_START  out  1  one-cycle start pulse to the transmitter.
- o_DATA  out  WIDTH  byte to the transmitter, held stable from o_START until the next o_START.
- o_DC  out  1  D/C to the transmitter, held like o_DATA.
- i_READY  in  1  transmitter idle/ready.
- o_BUSY  out  1  high in any state other than IDLE.
- o_ERR  out  1  sticky timeout flag. Tied to 0 without OLED_ARB_TIMEOUT_EN.

Behaviour:
- Reset:
  - State IDLE, round-robin pointer = 0.
  - o_GNT, o_ACK, o_START, o_DATA, o_DC, o_BUSY and o_ERR all 0.
  - Reset in any state aborts the operation immediately; no ACK is issued for an in-flight byte.
- All outputs are registered.
- States: IDLE, GRANT, WAIT_LOW, WAIT_HIGH.
- IDLE:
  - If any i_REQ is set, pick the first set bit searching upward from pointer, wrapping at NUM_REQ-1 → 0.
  - Set o_GNT to that one-hot value and go to GRANT.
  - Latency: request sampled at edge n gives o_GNT at edge n+1.
- GRANT (granted index g):
  - If i_REQ[g]=0 (requester withdrew), clear o_GNT, go to IDLE, pointer unchanged.
  - Else, if i_READY=1: at the next edge assert o_START=1 and o_ACK[g]=1 for exactly one cycle, latch o_DATA/o_DC from requester g, latch last = i_LAST[g], go to WAIT_LOW.
  - Else stay in GRANT.
  - Minimum request-to-start latency is 2 cycles.
- WAIT_LOW: wait for i_READY=0 (transmitter accepted), then go to WAIT_HIGH.
- WAIT_HIGH: wait for i_READY=1 (byte shifted out). Then:
  - If last=1, or i_REQ[g]=0 on that cycle: clear o_GNT, set pointer = (g+1) mod NUM_REQ, go to IDLE.
  - Else: keep o_GNT and go to GRANT (burst continues).
- Requester contract: after o_ACK[g] the requester updates i_DATA/i_DC/i_LAST within one cycle, or drops i_REQ[g].
- Simultaneous requests are resolved purely by the pointer; no fixed priority.
- o_GNT is never multi-hot and never changes within a burst.
- Next-grant rule: a non-granted requester raising i_REQ during a burst is served no earlier than IDLE after the burst ends. It is served next if it is the first set bit at/after the pointer.
- Exactly one o_START per o_ACK; never two o_START pulses without an intervening WAIT_HIGH exit.

Optional Feature:
- OLED_ARB_TIMEOUT_EN defined:
  - A counter clears on each state change.
  - If WAIT_LOW or WAIT_HIGH persists for TIMEOUT_CYCLES cycles: set o_ERR (sticky until i_RST), clear o_GNT, advance the pointer, go to IDLE.
- Undefined: no counter; o_ERR tied to 0; the block waits indefinitely.

Decomposition:
- Package oled_pkg: state encoding constants (IDLE=2'd0, GRANT=2'd1, WAIT_LOW=2'd2, WAIT_HIGH=2'd3), default NUM_REQ/WIDTH, D/C encoding constants.
- Sub-module oled_rr_picker: combinational round-robin picker.
  - Inputs: req vector, pointer.
  - Outputs: one-hot grant, index, any.
  - Instantiated once.

Test Plan:
- Single byte: i_REQ=3'b001, i_DATA[7:0]=8'hAE, i_DC[0]=0, i_LAST[0]=1; transmitter model drops READY 1 cycle after START for 40 cycles → o_GNT=001 at +1, o_START and o_ACK[0] at +2 with o_DATA=AE, o_DC=0; IDLE after READY returns; pointer=1.
- Simultaneous i_REQ=3'b111, all i_LAST=1, from reset → grant order 0,1,2,0 across four transfers; o_GNT always one-hot.
- Burst lock: req0 sends A0,A1,A2 with i_LAST only on A2; req1 requests during A0 → three consecutive starts for req0, then req1 granted.
- Withdrawal: grant req2 with i_READY=0, then drop i_REQ[2] → o_GNT clears next cycle, no o_START/o_ACK, pointer unchanged.
- Reset mid-transfer: assert i_RST in WAIT_HIGH → next cycle all outputs 0, state IDLE; a subsequent request starts cleanly from pointer 0.
- With OLED_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=16: hold i_READY=0 after START → o_ERR=1 after 16 cycles, grant released, o_ERR remains 1 until i_RST.
